// File: rtl/perf_monitor_pkg.sv
// perf_mon_pkg: shared state type and default sizing for the performance monitor.
// Build option PERF_MON_SAT_EN (see perf_counter) selects saturating counters.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pm_state_t;

    localparam int unsigned DEF_CNT_W   = 32;
    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_NUM_EVT = 4;

endpackage

// File: rtl/perf_monitor_if.sv
// perf_monitor_if: observation inputs and count outputs of the performance monitor.
// master = core/software side, slave = the monitor itself.
interface perf_monitor_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned NUM_EVT = 4
);
    logic                     start;
    logic                     abort;
    logic [PC_W-1:0]          stop_pc;
    logic [PC_W-1:0]          pc;
    logic                     retire;
    logic [NUM_EVT-1:0]       evt;
    logic [CNT_W-1:0]         cycle_cnt;
    logic [CNT_W-1:0]         instr_cnt;
    logic [NUM_EVT*CNT_W-1:0] evt_cnt;
    logic                     running;
    logic                     done;
    logic                     ovf;

    modport master (
        output start, abort, stop_pc, pc, retire, evt,
        input  cycle_cnt, instr_cnt, evt_cnt, running, done, ovf
    );

    modport slave (
        input  start, abort, stop_pc, pc, retire, evt,
        output cycle_cnt, instr_cnt, evt_cnt, running, done, ovf
    );
endinterface

// File: rtl/perf_counter.sv
// perf_counter: one W-bit event counter with synchronous clear.
// Build option PERF_MON_SAT_EN: saturate at all-ones instead of wrapping.
// ovf_pulse is high on any increment attempted from all-ones.
module perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         ovf_pulse
);
    logic at_max;
    logic bump;

    assign at_max    = (value == '1);
    assign bump      = en & inc & ~clr;
    assign ovf_pulse = bump & at_max;

    // Count register: clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (bump) begin
`ifdef PERF_MON_SAT_EN
            if (!at_max) begin
                value <= value + W'(1);
            end
`else
            value <= value + W'(1);
`endif
        end
    end
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: counts cycles, retired instructions and NUM_EVT event channels
// from a start pulse until pc >= stop_pc, then freezes counts and flags done.
// Build option PERF_MON_SAT_EN: counters saturate instead of wrapping.
module perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned NUM_EVT = DEF_NUM_EVT
) (
    input logic            clk,
    input logic            reset,
    perf_monitor_if.slave  bus
);
    pm_state_t            state_q;
    pm_state_t            state_d;
    logic                 stop_hit;
    logic                 cnt_en;
    logic [NUM_EVT+1:0]   ovf_pulse;
    logic                 ovf_q;

    assign stop_hit = (bus.pc >= bus.stop_pc);
    // Increments apply on every RUN edge, including the stop and abort edges;
    // a start edge only clears.
    assign cnt_en   = (state_q == RUN) & ~bus.start;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start beats stop, stop beats abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.start)      state_d = RUN;
                else if (stop_hit)  state_d = DONE;
                else if (bus.abort) state_d = IDLE;
            end
            DONE: begin
                if (bus.start)      state_d = RUN;
                else if (bus.abort) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .reset(reset), .clr(bus.start), .inc(1'b1), .en(cnt_en),
        .value(bus.cycle_cnt), .ovf_pulse(ovf_pulse[0])
    );

    perf_counter #(.W(CNT_W)) u_instr_cnt (
        .clk(clk), .reset(reset), .clr(bus.start), .inc(bus.retire), .en(cnt_en),
        .value(bus.instr_cnt), .ovf_pulse(ovf_pulse[1])
    );

    for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
        perf_counter #(.W(CNT_W)) u_evt_cnt (
            .clk(clk), .reset(reset), .clr(bus.start), .inc(bus.evt[i]), .en(cnt_en),
            .value(bus.evt_cnt[i*CNT_W +: CNT_W]), .ovf_pulse(ovf_pulse[i+2])
        );
    end

    // Sticky overflow flag, cleared only by start or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (bus.start) begin
            ovf_q <= 1'b0;
        end else if (|ovf_pulse) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed vector table plus hand-written multi-cycle sequences.
// Honours PERF_MON_SAT_EN for the narrow-counter overflow expectation.
module tb_perf_monitor;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    perf_monitor_if #(.CNT_W(32), .PC_W(32), .NUM_EVT(4)) u_if ();
    perf_monitor_if #(.CNT_W(4),  .PC_W(32), .NUM_EVT(4)) u_if4 ();

    perf_monitor #(.CNT_W(32), .PC_W(32), .NUM_EVT(4)) dut (
        .clk(clk), .reset(reset), .bus(u_if)
    );

    perf_monitor #(.CNT_W(4), .PC_W(32), .NUM_EVT(4)) dut4 (
        .clk(clk), .reset(reset), .bus(u_if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic [31:0] pc;
        logic        retire;
        logic [3:0]  evt;
        logic [31:0] e_cyc;
        logic [31:0] e_ins;
        logic        e_run;
        logic        e_done;
        logic [31:0] e_evt0;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.start  = 1'b0;
        u_if.abort  = 1'b0;
        u_if.pc     = '0;
        u_if.retire = 1'b0;
        u_if.evt    = '0;
    endtask

    // Start, then step pc by 4 from 0 until done; retire every or every other cycle.
    task automatic run_to_stop(input bit alt, input logic [31:0] exp_ins, input string tag);
        bit finished;
        idle_inputs();
        u_if.stop_pc = 32'd400;
        u_if.start   = 1'b1;
        cyc();
        u_if.start = 1'b0;
        finished   = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            u_if.pc     = 32'(4 * k);
            u_if.retire = alt ? (k % 2 == 0) : 1'b1;
            cyc();
            finished = u_if.done;
        end
        idle_inputs();
        check({tag, "_reached_done"}, 64'(finished), 64'd1);
        check({tag, "_cycle_cnt"}, 64'(u_if.cycle_cnt), 64'd101);
        check({tag, "_instr_cnt"}, 64'(u_if.instr_cnt), 64'(exp_ins));
        check({tag, "_running"}, 64'(u_if.running), 64'd0);
        check({tag, "_done"}, 64'(u_if.done), 64'd1);
        check({tag, "_ovf"}, 64'(u_if.ovf), 64'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle_inputs();
        u_if.stop_pc  = 32'd20;
        u_if4.start   = 1'b0;
        u_if4.abort   = 1'b0;
        u_if4.pc      = '0;
        u_if4.stop_pc = '1;
        u_if4.retire  = 1'b0;
        u_if4.evt     = '0;
        reset = 1'b1;
        #23;
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_cycle_cnt", 64'(u_if.cycle_cnt), 64'd0);
        check("rst_instr_cnt", 64'(u_if.instr_cnt), 64'd0);
        check("rst_evt_cnt", 64'(u_if.evt_cnt), 64'd0);
        check("rst_running", 64'(u_if.running), 64'd0);
        check("rst_done", 64'(u_if.done), 64'd0);
        check("rst_ovf", 64'(u_if.ovf), 64'd0);

        // Cycle table with stop_pc = 20
        //          start abort pc     ret evt      cyc   ins   run   done  evt0
        tbl[0]  = '{1'b1, 1'b0, 32'd0,   1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'd0,   1'b1, 4'd1, 32'd1, 32'd1, 1'b1, 1'b0, 32'd1};
        tbl[2]  = '{1'b0, 1'b0, 32'd4,   1'b0, 4'd0, 32'd2, 32'd1, 1'b1, 1'b0, 32'd1};
        tbl[3]  = '{1'b0, 1'b1, 32'd24,  1'b1, 4'd1, 32'd3, 32'd2, 1'b0, 1'b1, 32'd2};
        tbl[4]  = '{1'b0, 1'b0, 32'd28,  1'b1, 4'd1, 32'd3, 32'd2, 1'b0, 1'b1, 32'd2};
        tbl[5]  = '{1'b1, 1'b0, 32'd0,   1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[6]  = '{1'b0, 1'b0, 32'd0,   1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 1'b0, 32'd0};
        tbl[7]  = '{1'b0, 1'b1, 32'd4,   1'b0, 4'd0, 32'd2, 32'd1, 1'b0, 1'b0, 32'd0};
        tbl[8]  = '{1'b0, 1'b0, 32'd100, 1'b1, 4'd1, 32'd2, 32'd1, 1'b0, 1'b0, 32'd0};
        tbl[9]  = '{1'b1, 1'b0, 32'd0,   1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[10] = '{1'b1, 1'b0, 32'd0,   1'b1, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
        tbl[11] = '{1'b0, 1'b0, 32'd0,   1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 1'b0, 32'd0};
        tbl[12] = '{1'b0, 1'b1, 32'd0,   1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0};

        for (int i = 0; i < 13; i++) begin
            u_if.start  = tbl[i].start;
            u_if.abort  = tbl[i].abort;
            u_if.pc     = tbl[i].pc;
            u_if.retire = tbl[i].retire;
            u_if.evt    = tbl[i].evt;
            cyc();
            check($sformatf("vec%0d_cycle_cnt", i), 64'(u_if.cycle_cnt), 64'(tbl[i].e_cyc));
            check($sformatf("vec%0d_instr_cnt", i), 64'(u_if.instr_cnt), 64'(tbl[i].e_ins));
            check($sformatf("vec%0d_running", i), 64'(u_if.running), 64'(tbl[i].e_run));
            check($sformatf("vec%0d_done", i), 64'(u_if.done), 64'(tbl[i].e_done));
            check($sformatf("vec%0d_evt0", i), 64'(u_if.evt_cnt[31:0]), 64'(tbl[i].e_evt0));
        end
        idle_inputs();
        check("tbl_ovf", 64'(u_if.ovf), 64'd0);

        // Full runs to stop_pc = 400
        run_to_stop(1'b0, 32'd101, "run_all");
        run_to_stop(1'b1, 32'd51, "run_alt");
        check("run_alt_cpi", 64'(u_if.cycle_cnt + 32'd1), 64'(2 * u_if.instr_cnt));

        // Event channels then abort on the 10th RUN edge
        u_if.stop_pc = '1;
        u_if.start   = 1'b1;
        cyc();
        u_if.start = 1'b0;
        u_if.evt   = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            u_if.abort = (i == 9);
            cyc();
        end
        idle_inputs();
        u_if.evt = 4'b1111;
        cyc();
        cyc();
        u_if.evt = '0;
        check("abort_running", 64'(u_if.running), 64'd0);
        check("abort_done", 64'(u_if.done), 64'd0);
        check("abort_cycle_cnt", 64'(u_if.cycle_cnt), 64'd10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_evt%0d", i), 64'(u_if.evt_cnt[i*32 +: 32]),
                  (i % 2 == 0) ? 64'd10 : 64'd0);
        end

        // Narrow counters: 20 RUN edges on a 4-bit build
        u_if4.start = 1'b1;
        cyc();
        u_if4.start = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
`ifdef PERF_MON_SAT_EN
        check("w4_cycle_cnt", 64'(u_if4.cycle_cnt), 64'd15);
`else
        check("w4_cycle_cnt", 64'(u_if4.cycle_cnt), 64'd4);
`endif
        check("w4_ovf", 64'(u_if4.ovf), 64'd1);
        check("w4_instr_cnt", 64'(u_if4.instr_cnt), 64'd0);
        u_if4.start = 1'b1;
        cyc();
        u_if4.start = 1'b0;
        check("w4_ovf_cleared", 64'(u_if4.ovf), 64'd0);

        // Asynchronous reset mid-RUN at count 37
        u_if.stop_pc = '1;
        u_if.start   = 1'b1;
        u_if.retire  = 1'b1;
        u_if.evt     = 4'b0001;
        cyc();
        u_if.start = 1'b0;
        for (int i = 0; i < 37; i++) cyc();
        check("pre_rst_cycle_cnt", 64'(u_if.cycle_cnt), 64'd37);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_cycle_cnt", 64'(u_if.cycle_cnt), 64'd0);
        check("async_rst_instr_cnt", 64'(u_if.instr_cnt), 64'd0);
        check("async_rst_evt_cnt", 64'(u_if.evt_cnt), 64'd0);
        check("async_rst_running", 64'(u_if.running), 64'd0);
        check("async_rst_done", 64'(u_if.done), 64'd0);
        check("async_rst_ovf", 64'(u_if.ovf), 64'd0);
        idle_inputs();
        #1;
        reset = 1'b0;
        cyc();
        check("post_rst_idle", 64'(u_if.running), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
